// File: rtl/uart_cmd_host.sv
// Host-side UART command initiator: serialises write/read/ALU frames and collects the response bytes.
// Optional stray-byte counter output enabled by defining UART_CMD_HOST_STRAY_CNT_EN.
module uart_cmd_host #(
    parameter int unsigned TIMEOUT_CYCLES = 65535,
    parameter int unsigned TO_W           = 16
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [1:0]  cmd_op,
    input  logic [3:0]  cmd_addr,
    input  logic [7:0]  cmd_wdata,
    input  logic [7:0]  cmd_opa,
    input  logic [7:0]  cmd_opb,
    input  logic [3:0]  cmd_fun,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic        rsp_valid,
    output logic [15:0] rsp_data,
    output logic        rsp_timeout,
    output logic        busy
`ifdef UART_CMD_HOST_STRAY_CNT_EN
    ,
    output logic [7:0]  stray_cnt
`endif
);

    localparam logic [1:0] OP_WR   = 2'b00;
    localparam logic [1:0] OP_RD   = 2'b01;
    localparam logic [1:0] OP_ALU  = 2'b10;
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {S_IDLE, S_SEND, S_WAIT_RX, S_DONE} state_e;

    state_e          state_q, state_d;
    logic [1:0]      op_q, op_d;
    logic [3:0]      addr_q, addr_d, fun_q, fun_d;
    logic [7:0]      wdata_q, wdata_d, opa_q, opa_d, opb_q, opb_d;
    logic [1:0]      idx_q, idx_d, rx_cnt_q, rx_cnt_d;
    logic            tx_valid_q, tx_valid_d;
    logic [7:0]      tx_data_q, tx_data_d;
    logic [TO_W-1:0] to_cnt_q, to_cnt_d;
    logic [7:0]      rxb0_q, rxb0_d, rxb1_q, rxb1_d;
    logic            rsp_valid_q, rsp_valid_d, rsp_timeout_q, rsp_timeout_d;
    logic [15:0]     rsp_data_q, rsp_data_d;

    logic       accept, tx_hs, rx_take, rx_last, to_hit, last_byte;
    logic [1:0] last_idx, exp_rx, idx_nxt;
    logic [7:0] hdr, next_byte, nb0, nb1;
    logic [15:0] rsp_asm;

    assign cmd_ready   = (state_q == S_IDLE);
    assign busy        = (state_q != S_IDLE);
    assign tx_valid    = tx_valid_q;
    assign tx_data     = tx_data_q;
    assign rsp_valid   = rsp_valid_q;
    assign rsp_data    = rsp_data_q;
    assign rsp_timeout = rsp_timeout_q;

    assign accept    = cmd_valid && cmd_ready;
    assign tx_hs     = tx_valid_q && tx_ready;
    assign idx_nxt   = idx_q + 2'd1;
    assign last_byte = (idx_q == last_idx);
    assign rx_take   = (state_q == S_WAIT_RX) && rx_valid;
    assign rx_last   = rx_take && ((rx_cnt_q + 2'd1) == exp_rx);
    // A byte arriving on the terminal count cycle takes priority over the timeout.
    assign to_hit    = (state_q == S_WAIT_RX) && !rx_valid && (to_cnt_q == TO_LAST);
    assign nb0       = (rx_take && rx_cnt_q == 2'd0) ? rx_data : rxb0_q;
    assign nb1       = (rx_take && rx_cnt_q == 2'd1) ? rx_data : rxb1_q;
    assign rsp_asm   = (op_q == OP_RD) ? {8'h00, nb0} : {nb1, nb0};

    always_comb begin
        hdr       = 8'hDD;
        last_idx  = 2'd1;
        exp_rx    = 2'd2;
        next_byte = {4'h0, fun_q};
        case (cmd_op)
            2'b00:   hdr = 8'hAA;
            2'b01:   hdr = 8'hBB;
            2'b10:   hdr = 8'hCC;
            default: hdr = 8'hDD;
        endcase
        case (op_q)
            OP_WR: begin
                last_idx  = 2'd2;
                exp_rx    = 2'd0;
                next_byte = (idx_nxt == 2'd1) ? {4'h0, addr_q} : wdata_q;
            end
            OP_RD: begin
                exp_rx    = 2'd1;
                next_byte = {4'h0, addr_q};
            end
            OP_ALU: begin
                last_idx = 2'd3;
                case (idx_nxt)
                    2'd1:    next_byte = opa_q;
                    2'd2:    next_byte = opb_q;
                    default: next_byte = {4'h0, fun_q};
                endcase
            end
            default: ;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RST) state_q <= S_IDLE;
        else      state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:    if (accept) state_d = S_SEND;
            S_SEND:    if (tx_hs && last_byte) state_d = (op_q == OP_WR) ? S_DONE : S_WAIT_RX;
            S_WAIT_RX: if (rx_last || to_hit) state_d = S_DONE;
            default:   state_d = S_IDLE;
        endcase
    end

    always_comb begin
        op_d = op_q;  addr_d = addr_q;  wdata_d = wdata_q;
        opa_d = opa_q;  opb_d = opb_q;  fun_d = fun_q;
        idx_d = idx_q;  tx_valid_d = tx_valid_q;  tx_data_d = tx_data_q;
        to_cnt_d = to_cnt_q;  rx_cnt_d = rx_cnt_q;  rxb0_d = rxb0_q;  rxb1_d = rxb1_q;
        rsp_valid_d = 1'b0;  rsp_data_d = rsp_data_q;  rsp_timeout_d = rsp_timeout_q;
        case (state_q)
            S_IDLE: if (accept) begin
                op_d = cmd_op;  addr_d = cmd_addr;  wdata_d = cmd_wdata;
                opa_d = cmd_opa;  opb_d = cmd_opb;  fun_d = cmd_fun;
                idx_d = 2'd0;  tx_valid_d = 1'b1;  tx_data_d = hdr;
            end
            S_SEND: if (tx_hs) begin
                if (last_byte) begin
                    tx_valid_d = 1'b0;
                    to_cnt_d = '0;  rx_cnt_d = '0;  rxb0_d = '0;  rxb1_d = '0;
                    if (op_q == OP_WR) begin
                        rsp_valid_d = 1'b1;  rsp_data_d = '0;  rsp_timeout_d = 1'b0;
                    end
                end else begin
                    idx_d = idx_nxt;
                    tx_data_d = next_byte;
                end
            end
            S_WAIT_RX: begin
                rxb0_d = nb0;
                rxb1_d = nb1;
                if (rx_valid) begin
                    to_cnt_d = '0;
                    rx_cnt_d = rx_cnt_q + 2'd1;
                end else begin
                    to_cnt_d = to_cnt_q + 1'b1;
                end
                if (rx_last || to_hit) begin
                    rsp_valid_d = 1'b1;  rsp_data_d = rsp_asm;  rsp_timeout_d = to_hit;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RST) begin
            op_q <= '0;  addr_q <= '0;  wdata_q <= '0;  opa_q <= '0;  opb_q <= '0;  fun_q <= '0;
            idx_q <= '0;  tx_valid_q <= 1'b0;  tx_data_q <= '0;
            to_cnt_q <= '0;  rx_cnt_q <= '0;  rxb0_q <= '0;  rxb1_q <= '0;
            rsp_valid_q <= 1'b0;  rsp_data_q <= '0;  rsp_timeout_q <= 1'b0;
        end else begin
            op_q <= op_d;  addr_q <= addr_d;  wdata_q <= wdata_d;
            opa_q <= opa_d;  opb_q <= opb_d;  fun_q <= fun_d;
            idx_q <= idx_d;  tx_valid_q <= tx_valid_d;  tx_data_q <= tx_data_d;
            to_cnt_q <= to_cnt_d;  rx_cnt_q <= rx_cnt_d;  rxb0_q <= rxb0_d;  rxb1_q <= rxb1_d;
            rsp_valid_q <= rsp_valid_d;  rsp_data_q <= rsp_data_d;  rsp_timeout_q <= rsp_timeout_d;
        end
    end

`ifdef UART_CMD_HOST_STRAY_CNT_EN
    logic [7:0] stray_q;
    logic       stray_hit;
    assign stray_hit = rx_valid && ((state_q != S_WAIT_RX) || (rx_cnt_q == exp_rx));
    assign stray_cnt = stray_q;

    always_ff @(posedge CLK) begin
        if (!RST)                                stray_q <= '0;
        else if (stray_hit && stray_q != 8'hFF)  stray_q <= stray_q + 8'd1;
    end
`endif

endmodule

// File: tb/tb_uart_cmd_host.sv
// Directed self-checking bench for uart_cmd_host (TIMEOUT_CYCLES = 100).
module tb_uart_cmd_host;

    logic        CLK = 1'b0;
    logic        RST, cmd_valid, cmd_ready, tx_valid, tx_ready, rx_valid;
    logic        rsp_valid, rsp_timeout, busy;
    logic [1:0]  cmd_op;
    logic [3:0]  cmd_addr, cmd_fun;
    logic [7:0]  cmd_wdata, cmd_opa, cmd_opb, tx_data, rx_data;
    logic [15:0] rsp_data;
`ifdef UART_CMD_HOST_STRAY_CNT_EN
    logic [7:0]  stray_cnt;
`endif

    always #5 CLK = ~CLK;

    uart_cmd_host #(.TIMEOUT_CYCLES(100), .TO_W(16)) dut (
        .CLK         (CLK),
        .RST         (RST),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_op      (cmd_op),
        .cmd_addr    (cmd_addr),
        .cmd_wdata   (cmd_wdata),
        .cmd_opa     (cmd_opa),
        .cmd_opb     (cmd_opb),
        .cmd_fun     (cmd_fun),
        .tx_data     (tx_data),
        .tx_valid    (tx_valid),
        .tx_ready    (tx_ready),
        .rx_data     (rx_data),
        .rx_valid    (rx_valid),
        .rsp_valid   (rsp_valid),
        .rsp_data    (rsp_data),
        .rsp_timeout (rsp_timeout),
        .busy        (busy)
`ifdef UART_CMD_HOST_STRAY_CNT_EN
        ,
        .stray_cnt   (stray_cnt)
`endif
    );

    typedef struct {
        logic [1:0]  op;
        logic [3:0]  addr;
        logic [7:0]  wdata, opa, opb;
        logic [3:0]  fun;
        int          stall;   // 0: tx_ready always 1, N: ready one cycle in N
        int          nbytes;
        logic [31:0] frame;   // byte 0 in bits [7:0]
        int          nrx;
        logic [15:0] rxb;     // rx byte 0 in bits [7:0]
        logic [15:0] rsp;
        logic        to;
        int          lat;     // cycles from last byte/handshake to rsp_valid, -1 = unchecked
    } vec_t;

    int n_run = 0;
    int n_fail = 0;
    int rsp_cnt = 0;

    always @(negedge CLK) if (rsp_valid === 1'b1) rsp_cnt++;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_run++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic [1:0] op, input logic [3:0] addr, input logic [7:0] wdata,
                                input logic [7:0] opa, input logic [7:0] opb, input logic [3:0] fun,
                                input int stall, input int nbytes, input logic [31:0] frame,
                                input int nrx, input logic [15:0] rxb, input logic [15:0] rsp,
                                input logic to, input int lat);
        vec_t v;
        v.op = op; v.addr = addr; v.wdata = wdata; v.opa = opa; v.opb = opb; v.fun = fun;
        v.stall = stall; v.nbytes = nbytes; v.frame = frame; v.nrx = nrx; v.rxb = rxb;
        v.rsp = rsp; v.to = to; v.lat = lat;
        return v;
    endfunction

    task automatic issue(input logic [1:0] op, input logic [3:0] addr, input logic [7:0] wdata,
                         input logic [7:0] opa, input logic [7:0] opb, input logic [3:0] fun);
        cmd_valid = 1'b1; cmd_op = op; cmd_addr = addr; cmd_wdata = wdata;
        cmd_opa = opa; cmd_opb = opb; cmd_fun = fun;
        tick();
        // scramble fields to prove they were captured on acceptance
        cmd_valid = 1'b0; cmd_op = ~op; cmd_addr = ~addr; cmd_wdata = ~wdata;
        cmd_opa = ~opa; cmd_opb = ~opb; cmd_fun = ~fun;
    endtask

    task automatic do_cmd(input vec_t v, input int id);
        int nb, cyc, k;
        logic stalled;
        logic [7:0] held, expb;
        logic [31:0] fr;
        logic [15:0] rb;
        fr = v.frame;
        rb = v.rxb;
        check($sformatf("v%0d_cmd_ready", id), {31'd0, cmd_ready}, 32'd1);
        issue(v.op, v.addr, v.wdata, v.opa, v.opb, v.fun);
        nb = 0; cyc = 0; stalled = 1'b0; held = 8'h00;
        while (nb < v.nbytes && cyc < 200) begin
            if (stalled)
                check($sformatf("v%0d_stall_hold", id), {23'd0, tx_valid, tx_data}, {23'd0, 1'b1, held});
            tx_ready = (v.stall == 0) || ((cyc % v.stall) == (v.stall - 1));
            stalled = 1'b0;
            if (tx_valid && tx_ready) begin
                expb = fr[8*nb +: 8];
                check($sformatf("v%0d_byte%0d", id, nb), {24'd0, tx_data}, {24'd0, expb});
                if (v.stall == 0)
                    check($sformatf("v%0d_byte%0d_cycle", id, nb), cyc, nb);
                nb++;
            end else if (tx_valid) begin
                stalled = 1'b1;
                held = tx_data;
            end
            tick();
            cyc++;
        end
        tx_ready = 1'b0;
        check($sformatf("v%0d_tx_count", id), nb, v.nbytes);
        check($sformatf("v%0d_tx_idle", id), {31'd0, tx_valid}, 32'd0);
        for (int i = 0; i < v.nrx; i++) begin
            if (i > 0) begin
                tick();
                tick();
            end
            rx_valid = 1'b1;
            rx_data = rb[8*i +: 8];
            tick();
            rx_valid = 1'b0;
            rx_data = 8'h00;
        end
        k = 0;
        while (!rsp_valid && k < 300) begin
            tick();
            k++;
        end
        check($sformatf("v%0d_rsp_valid", id), {31'd0, rsp_valid}, 32'd1);
        check($sformatf("v%0d_rsp_data", id), {16'd0, rsp_data}, {16'd0, v.rsp});
        check($sformatf("v%0d_rsp_timeout", id), {31'd0, rsp_timeout}, {31'd0, v.to});
        if (v.lat >= 0) check($sformatf("v%0d_latency", id), k, v.lat);
        tick();
        check($sformatf("v%0d_rsp_pulse", id), {31'd0, rsp_valid}, 32'd0);
        check($sformatf("v%0d_rsp_hold", id), {15'd0, rsp_timeout, rsp_data}, {15'd0, v.to, v.rsp});
        check($sformatf("v%0d_ready_back", id), {30'd0, cmd_ready, busy}, 32'd2);
    endtask

    vec_t vecs[9];
    int   base;

    initial begin
        vecs[0] = mk(2'b00, 4'h2, 8'h81, 8'h00, 8'h00, 4'h0, 0, 3, {8'h00, 8'h81, 8'h02, 8'hAA}, 0, 16'h0000, 16'h0000, 1'b0, -1);
        vecs[1] = mk(2'b01, 4'h5, 8'h00, 8'h00, 8'h00, 4'h0, 3, 2, {8'h00, 8'h00, 8'h05, 8'hBB}, 1, 16'h003C, 16'h003C, 1'b0, -1);
        vecs[2] = mk(2'b10, 4'h0, 8'h00, 8'h10, 8'h0F, 4'h0, 0, 4, {8'h00, 8'h0F, 8'h10, 8'hCC}, 2, 16'h001F, 16'h001F, 1'b0, -1);
        vecs[3] = mk(2'b11, 4'h0, 8'h00, 8'h00, 8'h00, 4'h2, 0, 2, {8'h00, 8'h00, 8'h02, 8'hDD}, 1, 16'h00F0, 16'h00F0, 1'b1, 100);
        vecs[4] = mk(2'b10, 4'h0, 8'h00, 8'hA5, 8'h5A, 4'hF, 2, 4, {8'h0F, 8'h5A, 8'hA5, 8'hCC}, 2, 16'h1234, 16'h1234, 1'b0, -1);
        vecs[5] = mk(2'b01, 4'hF, 8'h00, 8'h00, 8'h00, 4'h0, 0, 2, {8'h00, 8'h00, 8'h0F, 8'hBB}, 0, 16'h0000, 16'h0000, 1'b1, 100);
        vecs[6] = mk(2'b00, 4'hA, 8'hFF, 8'h00, 8'h00, 4'h0, 2, 3, {8'h00, 8'hFF, 8'h0A, 8'hAA}, 0, 16'h0000, 16'h0000, 1'b0, -1);
        vecs[7] = mk(2'b11, 4'h0, 8'h00, 8'h00, 8'h00, 4'h7, 1, 2, {8'h00, 8'h00, 8'h07, 8'hDD}, 2, 16'h8000, 16'h8000, 1'b0, -1);
        vecs[8] = mk(2'b10, 4'h0, 8'h00, 8'h01, 8'h02, 4'h3, 0, 4, {8'h03, 8'h02, 8'h01, 8'hCC}, 1, 16'h0099, 16'h0099, 1'b1, 100);

        // Reset, with a command offered throughout that must not be accepted
        RST = 1'b0; tx_ready = 1'b0; rx_valid = 1'b0; rx_data = 8'h00;
        cmd_valid = 1'b1; cmd_op = 2'b00; cmd_addr = 4'h1; cmd_wdata = 8'h11;
        cmd_opa = 8'h00; cmd_opb = 8'h00; cmd_fun = 4'h0;
        repeat (3) tick();
        check("reset_tx", {23'd0, tx_valid, tx_data}, 32'd0);
        check("reset_rsp", {14'd0, rsp_valid, rsp_timeout, rsp_data}, 32'd0);
        check("reset_busy_ready", {30'd0, busy, cmd_ready}, 32'd1);
        cmd_valid = 1'b0;
        RST = 1'b1;
        tick();
        check("reset_no_accept", {30'd0, busy, tx_valid}, 32'd0);
`ifdef UART_CMD_HOST_STRAY_CNT_EN
        check("reset_stray", {24'd0, stray_cnt}, 32'd0);
`endif

        // Back-to-back table-driven commands
        for (int i = 0; i < 9; i++) do_cmd(vecs[i], i);

        // rx_valid on the timeout terminal-count cycle wins
        issue(2'b01, 4'h3, 8'h00, 8'h00, 8'h00, 4'h0);
        tx_ready = 1'b1;
        tick();
        tick();
        tx_ready = 1'b0;
        repeat (99) tick();
        check("tc_not_early", {31'd0, rsp_valid}, 32'd0);
        rx_valid = 1'b1; rx_data = 8'h5A;
        tick();
        rx_valid = 1'b0; rx_data = 8'h00;
        check("tc_rx_wins", {14'd0, rsp_valid, rsp_timeout, rsp_data}, {14'd0, 1'b1, 1'b0, 16'h005A});
        tick();

        // Reset during the second byte of an ALU frame
        issue(2'b10, 4'h0, 8'h00, 8'h11, 8'h22, 4'h3);
        tx_ready = 1'b1;
        tick();
        check("rst_mid_byte1", {23'd0, tx_valid, tx_data}, {23'd0, 1'b1, 8'h11});
        base = rsp_cnt;
        RST = 1'b0;
        tick();
        check("rst_mid_drop", {30'd0, tx_valid, busy}, 32'd0);
        RST = 1'b1;
        tx_ready = 1'b0;
        repeat (150) tick();
        check("rst_mid_no_rsp", rsp_cnt, base);
        check("rst_mid_quiet", {30'd0, tx_valid, busy}, 32'd0);
        do_cmd(mk(2'b01, 4'h9, 8'h00, 8'h00, 8'h00, 4'h0, 0, 2, {8'h00, 8'h00, 8'h09, 8'hBB}, 1, 16'h00C3, 16'h00C3, 1'b0, -1), 20);

        // Stray bytes in IDLE and SEND are ignored
        for (int i = 0; i < 3; i++) begin
            rx_valid = 1'b1; rx_data = 8'hEE;
            tick();
            rx_valid = 1'b0;
            tick();
        end
        check("stray_idle", {31'd0, busy}, 32'd0);
        issue(2'b01, 4'h6, 8'h00, 8'h00, 8'h00, 4'h0);
        rx_valid = 1'b1; rx_data = 8'h77;
        tick();
        rx_valid = 1'b0; rx_data = 8'h00;
        check("stray_send", {23'd0, busy, tx_data}, {23'd0, 1'b1, 8'hBB});
        tx_ready = 1'b1;
        tick();
        tick();
        tx_ready = 1'b0;
        rx_valid = 1'b1; rx_data = 8'h42;
        tick();
        rx_valid = 1'b0; rx_data = 8'h00;
        check("stray_rsp", {14'd0, rsp_valid, rsp_timeout, rsp_data}, {14'd0, 1'b1, 1'b0, 16'h0042});
`ifdef UART_CMD_HOST_STRAY_CNT_EN
        check("stray_cnt", {24'd0, stray_cnt}, 32'd4);
`endif
        tick();

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
